// File: rtl/esm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | esm_pkg : shared types and widths for the ESM fetch path            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package esm_pkg;

    localparam int BS_DEFAULT = 16;
    localparam int IDX_W      = $clog2(BS_DEFAULT);
    localparam int CNT_W      = $clog2(BS_DEFAULT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/esm_slot_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | esm_slot_counter : saturating up/down occupancy counter with clear  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module esm_slot_counter #(
    parameter int W       = 5,
    parameter int MAX_VAL = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] c_max = MAX_VAL[W-1:0];

    logic [W-1:0] r_cnt;
    logic         w_dec;
    logic         w_inc;

    // A decrement at zero is dropped; an increment at the limit is only
    // allowed when a decrement lands in the same cycle.
    assign w_dec = dec && (r_cnt != '0);
    assign w_inc = inc && ((r_cnt != c_max) || w_dec);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_dec && !w_inc) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/esm_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | esm_fetch_unit : sequential instruction fetch into circular buffer  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module esm_fetch_unit
    import esm_pkg::*;
#(
    parameter int Instruction_word_size = 16,
    parameter int bs                    = BS_DEFAULT,
    parameter int ADDR_W                = 16,
    parameter int MAX_OUTST             = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [ADDR_W-1:0]                start_pc,
    input  logic                             redirect,
    input  logic [ADDR_W-1:0]                redirect_pc,
    input  logic                             buf_release,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic                             mem_rsp_valid,
    input  logic [Instruction_word_size-1:0] mem_rsp_data,
    output logic                             buf_wr_en,
    output logic [$clog2(bs)-1:0]            buf_wr_idx,
    output logic [Instruction_word_size-1:0] buf_wr_data,
    output logic                             buf_flush,
    output logic [$clog2(bs):0]              buf_count,
    output logic                             busy
);

    localparam int IW = $clog2(bs);
    localparam int CW = $clog2(bs) + 1;
    localparam logic [CW:0]   c_bs_lim   = bs[CW:0];
    localparam logic [CW-1:0] c_outst_lim = MAX_OUTST[CW-1:0];

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [IW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_drop;
    logic [CW-1:0]     w_drop_nxt;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_outst;
    logic [CW:0]       w_reserved;
    logic              w_active;
    logic              w_redir;
    logic              w_rsp;
    logic              w_keep;
    logic              w_req;
    logic              w_hs;

    assign w_active   = (r_state != IDLE);
    assign w_redir    = redirect && w_active;
    assign w_rsp      = mem_rsp_valid && w_active;
    assign w_keep     = w_rsp && (r_drop == '0) && !w_redir;
    // Slots are reserved at request time so responses can never overflow.
    assign w_reserved = {1'b0, w_count} + {1'b0, w_outst};
    assign w_req      = (r_state == RUN) && en && (w_reserved < c_bs_lim)
                        && (w_outst < c_outst_lim) && !redirect;
    assign w_hs       = w_req && mem_req_ready;

    assign mem_req_valid = w_req;
    assign mem_addr      = r_pc;
    assign buf_wr_en     = w_keep;
    assign buf_wr_idx    = r_wr_ptr;
    assign buf_wr_data   = w_keep ? mem_rsp_data : '0;
    assign buf_flush     = w_redir;
    assign buf_count     = w_count;
    assign busy          = w_active;

    esm_slot_counter #(.W(CW), .MAX_VAL(bs)) u_count (
        .clk (clk),
        .rst (rst),
        .clr (w_redir),
        .inc (w_keep),
        .dec (buf_release),
        .cnt (w_count)
    );

    esm_slot_counter #(.W(CW), .MAX_VAL(MAX_OUTST)) u_outst (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (w_hs),
        .dec (w_rsp),
        .cnt (w_outst)
    );

    always_comb begin
        w_drop_nxt = r_drop;
        // Everything still in flight after this cycle belongs to the old stream.
        if (w_redir) begin
            w_drop_nxt = w_outst - CW'(w_rsp);
        end else if (w_rsp && (r_drop != '0)) begin
            w_drop_nxt = r_drop - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_redir) begin
                    w_state_nxt = (w_drop_nxt != '0) ? DRAIN : RUN;
                end else if (!en && (w_outst == '0)) begin
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (w_redir) begin
                    w_state_nxt = (w_drop_nxt != '0) ? DRAIN : RUN;
                end else if (w_drop_nxt == '0) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_wr_ptr <= '0;
            r_drop   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            if ((r_state == IDLE) && en) begin
                r_pc <= start_pc;
            end else if (w_redir) begin
                r_pc <= redirect_pc;
            end else if (w_hs) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_redir) begin
                r_wr_ptr <= '0;
            end else if (w_keep) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_esm_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_esm_fetch_unit : directed bench with an in-order memory model    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_esm_fetch_unit;
    import esm_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [AW-1:0]     start_pc;
    logic              redirect;
    logic [AW-1:0]     redirect_pc;
    logic              buf_release;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [AW-1:0]     mem_addr;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rsp_data;
    logic              buf_wr_en;
    logic [IDX_W-1:0]  buf_wr_idx;
    logic [DW-1:0]     buf_wr_data;
    logic              buf_flush;
    logic [CNT_W-1:0]  buf_count;
    logic              busy;

    esm_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .start_pc      (start_pc),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .buf_release   (buf_release),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .buf_wr_en     (buf_wr_en),
        .buf_wr_idx    (buf_wr_idx),
        .buf_wr_data   (buf_wr_data),
        .buf_flush     (buf_flush),
        .buf_count     (buf_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
    } wr_vec_t;

    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] pend_q[$];
    logic [AW-1:0] req_log[$];
    int            wr_idx_log[$];
    logic [DW-1:0] wr_data_log[$];
    int            flush_cnt = 0;
    int            hold_viol = 0;
    logic          rsp_en = 1'b1;
    logic          stalled = 1'b0;
    logic [AW-1:0] stalled_addr = '0;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Memory model: accepted requests answered in order one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            if (mem_req_valid && stalled && (mem_addr != stalled_addr)) hold_viol++;
            stalled      = mem_req_valid && !mem_req_ready;
            stalled_addr = mem_addr;
            if (mem_req_valid && mem_req_ready) begin
                pend_q.push_back(mem_addr);
                req_log.push_back(mem_addr);
            end
            if (buf_wr_en) begin
                wr_idx_log.push_back(int'(buf_wr_idx));
                wr_data_log.push_back(buf_wr_data);
            end
            if (buf_flush) flush_cnt++;
        end
        #1;
        if (rsp_en && (pend_q.size() > 0)) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = word_of(pend_q.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #2;
    endtask

    task automatic wait_reqs(input string name, input int target, input int budget);
        int k = 0;
        while ((req_log.size() < target) && (k < budget)) begin
            tick(1);
            k++;
        end
        chk(name, req_log.size(), target);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy && (k < budget)) begin
            tick(1);
            k++;
        end
        chk(name, busy, 1'b0);
    endtask

    task automatic release_n(input int n);
        buf_release = 1'b1;
        tick(n);
        buf_release = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_vec_t vec[17];
        int      n0;
        int      w0;
        int      f0;

        for (int i = 0; i < 16; i++) vec[i] = '{i, 16'h0100 + AW'(i)};
        vec[16] = '{0, 16'h0110};

        rst = 1'b0; en = 1'b0; redirect = 1'b0; buf_release = 1'b0;
        mem_req_ready = 1'b1; start_pc = '0; redirect_pc = '0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        tick(3);
        chk("reset_ctrl", {mem_req_valid, buf_wr_en, buf_flush, busy}, 4'h0);
        chk("reset_count", buf_count, 0);
        chk("reset_addr", mem_addr, 0);
        rst = 1'b1;
        tick(2);
        chk("idle_no_req", {mem_req_valid, busy}, 2'b00);

        // Fill the buffer from 0x0100 with no releases.
        start_pc = 16'h0100;
        en = 1'b1;
        tick(40);
        chk("fill_writes", wr_idx_log.size(), 16);
        chk("fill_reqs", req_log.size(), 16);
        chk("fill_count", buf_count, 16);
        chk("fill_blocked", mem_req_valid, 1'b0);

        // One release from full refills exactly one slot.
        release_n(1);
        tick(10);
        chk("refill_reqs", req_log.size(), 17);
        chk("refill_addr", req_log[16], 16'h0110);
        chk("refill_count", buf_count, 16);
        for (int i = 0; i < 17; i++) begin
            if (i < wr_idx_log.size()) begin
                chk($sformatf("wr_idx[%0d]", i), wr_idx_log[i], vec[i].idx);
                chk($sformatf("wr_data[%0d]", i), wr_data_log[i], word_of(vec[i].addr));
            end else begin
                chk($sformatf("wr_present[%0d]", i), wr_idx_log.size(), i + 1);
            end
        end

        // Outstanding limit with responses held back.
        en = 1'b0;
        wait_idle("idle_after_en0", 20);
        chk("retain_count", buf_count, 16);
        release_n(17);
        chk("release_floor", buf_count, 0);
        rsp_en = 1'b0;
        n0 = req_log.size();
        w0 = wr_idx_log.size();
        start_pc = 16'h0300;
        en = 1'b1;
        tick(10);
        chk("outst_limit", req_log.size() - n0, 4);
        chk("outst_blocked", mem_req_valid, 1'b0);
        rsp_en = 1'b1;
        tick(8);
        chk("outst_resume", (req_log.size() - n0) > 4, 1'b1);
        if (wr_idx_log.size() > w0) begin
            chk("outst_first_idx", wr_idx_log[w0], 1);
            chk("outst_first_data", wr_data_log[w0], word_of(16'h0300));
        end else begin
            chk("outst_first_write", wr_idx_log.size(), w0 + 1);
        end

        // Redirect with two words buffered and three requests in flight.
        en = 1'b0;
        wait_idle("idle_before_redirect", 30);
        release_n(20);
        n0 = req_log.size();
        start_pc = 16'h0400;
        en = 1'b1;
        wait_reqs("redir_pre2", n0 + 2, 10);
        mem_req_ready = 1'b0;
        tick(4);
        chk("redir_pre_count", buf_count, 2);
        rsp_en = 1'b0;
        mem_req_ready = 1'b1;
        wait_reqs("redir_pre3", n0 + 5, 10);
        mem_req_ready = 1'b0;
        tick(2);
        f0 = flush_cnt;
        w0 = wr_idx_log.size();
        redirect_pc = 16'h0200;
        redirect = 1'b1;
        mem_req_ready = 1'b1;
        rsp_en = 1'b1;
        tick(1);
        redirect = 1'b0;
        chk("redir_count_clr", buf_count, 0);
        chk("drain_no_req", {mem_req_valid, busy}, 2'b01);
        tick(12);
        chk("flush_pulses", flush_cnt - f0, 1);
        if ((req_log.size() > n0 + 5) && (wr_idx_log.size() > w0)) begin
            chk("redir_addr", req_log[n0 + 5], 16'h0200);
            chk("redir_wr_idx", wr_idx_log[w0], 0);
            chk("redir_wr_data", wr_data_log[w0], word_of(16'h0200));
        end else begin
            chk("redir_progress", (req_log.size() > n0 + 5) && (wr_idx_log.size() > w0), 1'b1);
        end

        // Address wrap with ready toggling.
        en = 1'b0;
        wait_idle("idle_before_wrap", 30);
        release_n(20);
        hold_viol = 0;
        n0 = req_log.size();
        start_pc = 16'hFFFE;
        mem_req_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            mem_req_ready = ~mem_req_ready;
        end
        if (req_log.size() >= n0 + 3) begin
            chk("wrap_a0", req_log[n0], 16'hFFFE);
            chk("wrap_a1", req_log[n0 + 1], 16'hFFFF);
            chk("wrap_a2", req_log[n0 + 2], 16'h0000);
        end else begin
            chk("wrap_reqs", req_log.size() >= n0 + 3, 1'b1);
        end
        chk("addr_hold", hold_viol, 0);

        // Asynchronous reset with two requests in flight.
        mem_req_ready = 1'b0;
        tick(4);
        n0 = req_log.size();
        rsp_en = 1'b0;
        mem_req_ready = 1'b1;
        wait_reqs("rst_pre", n0 + 2, 10);
        mem_req_ready = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("async_ctrl", {mem_req_valid, buf_wr_en, buf_flush, busy}, 4'h0);
        chk("async_count", buf_count, 0);
        chk("async_addr_idx", {mem_addr, 4'(buf_wr_idx)}, 0);
        pend_q.delete();
        rsp_en = 1'b1;
        en = 1'b0;
        mem_req_ready = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(3);
        chk("post_rst_idle", {busy, mem_req_valid}, 2'b00);
        chk("post_rst_count", buf_count, 0);
        start_pc = 16'h0500;
        en = 1'b1;
        tick(30);
        chk("post_rst_fill", buf_count, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/esm_fetch_unit.md
Name: esm_fetch_unit

Overview:
Upstream fetch stage of the ESM. It issues sequential instruction addresses to instruction memory and writes returned words into the circular instruction buffer at a managed write index. Buffer slots are reserved at request time, so a response never overflows the buffer. Slots are freed by release pulses from ESM_Core. A redirect from ESM_Core flushes the buffer and restarts fetch at a new address.

Parameters:
Instruction_word_size, 16, instruction width in bits
bs, 16, buffer depth in instructions; power of two, at least 2
ADDR_W, 16, instruction-memory word-address width
MAX_OUTST, 4, maximum outstanding memory requests; at least 1, at most bs

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-low
en  in  1  fetch enable
start_pc  in  ADDR_W  fetch start address, sampled in IDLE when en=1
redirect  in  1  one-cycle pulse: flush and refetch from redirect_pc
redirect_pc  in  ADDR_W  new fetch address
buf_release  in  1  ESM_Core consumed one buffer entry
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  request word address
mem_rsp_valid  in  1  in-order response valid; no backpressure
mem_rsp_data  in  Instruction_word_size  response instruction
buf_wr_en  out  1  buffer write strobe
buf_wr_idx  out  $clog2(bs)  buffer write slot
buf_wr_data  out  Instruction_word_size  word to write
buf_flush  out  1  one-cycle pulse: ESM_Core read index returns to 0
buf_count  out  $clog2(bs)+1  valid entries in the buffer
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; pc=0, wr_ptr=0, count=0, outst=0, drop=0. All outputs are 0.
- IDLE: when en=1, pc<=start_pc and the next state is RUN. No requests are issued in IDLE.
- RUN:
  - mem_req_valid = en && (count+outst < bs) && (outst < MAX_OUTST) && !redirect.
  - mem_addr = pc.
  - On handshake (valid && ready): pc<=pc+1, wrapping mod 2^ADDR_W; outst increments.
- Response while drop=0:
  - buf_wr_en, buf_wr_idx and buf_wr_data are combinational from mem_rsp_valid and mem_rsp_data; zero added latency.
  - wr_ptr increments mod bs; count increments; outst decrements.
- Response while drop>0: the word is discarded, drop decrements, outst decrements, and there is no write.
- buf_release with count>0: count decrements. buf_release with count=0 is ignored.
- Same-cycle handshake, response and release: each counter applies its net change. count+outst never exceeds bs.
- redirect (in RUN or DRAIN; priority over release and handshake in the same cycle):
  - count<=0, wr_ptr<=0, pc<=redirect_pc.
  - drop<=outst minus any non-dropped response arriving that cycle; that response is also discarded and not written.
  - buf_flush=1 for one cycle.
  - Next state is DRAIN if the new drop>0, otherwise RUN.
- DRAIN: no requests are issued. When drop reaches 0, the next state is RUN.
- en=0 in RUN:
  - Requests stop; outstanding responses still complete.
  - The next state is IDLE once outst=0. Buffer contents and count are retained.
- Redirect in IDLE is ignored.
- A mid-operation reset aborts everything. Late memory responses after reset are the environment's responsibility; the fetch unit writes nothing while in IDLE.

Decomposition:
- Shared package esm_pkg holds:
  - fetch state enum {IDLE, RUN, DRAIN};
  - IDX_W=$clog2(bs);
  - CNT_W=$clog2(bs)+1.
- One sub-module, esm_slot_counter, is natural: the up/down occupancy and reservation counter with saturation checks, reusable by ESM_Core.

Test Plan:
1. Reset, then en=1, start_pc=0x0100, ready=1, responses arrive one cycle after request, no release -> exactly 16 writes at idx 0..15 with addresses 0x0100..0x010F; buf_count=16; mem_req_valid stays 0.
2. From full, one buf_release pulse -> a single request to 0x0110 is issued; its word is written to idx 0; buf_count returns to 16.
3. MAX_OUTST=4, responses held for 10 cycles -> at most 4 requests accepted; the 5th valid is blocked until the first response returns.
4. Redirect to 0x0200 with 3 outstanding -> buf_flush pulses; the 3 returned words are not written; the DRAIN→RUN transition occurs; the first write is idx 0 with the word fetched from 0x0200.
5. start_pc=0xFFFE, mem_req_ready toggling 1/0 -> addresses go 0xFFFE, 0xFFFF, 0x0000; the address is held stable while ready=0.
6. rst=0 asserted mid-burst with outst=2 -> all outputs are 0 immediately (asynchronous); after release the unit is in IDLE with buf_count=0.
